// File: rtl/uart_tx_cfg_if.sv
// Word-source side of the configurable UART transmitter: handshake, word,
// per-frame configuration and the status/serial outputs.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int CLK_DIV_WIDTH = 16
);
  logic                     i_Tx_DV;
  logic [DATA_WIDTH-1:0]    i_Tx_Byte;
  logic [CLK_DIV_WIDTH-1:0] i_Clks_Per_Bit;
  logic [1:0]               i_Parity_Mode;
  logic                     i_Two_Stop;
  logic                     o_Tx_Ready;
  logic                     o_Tx_Active;
  logic                     o_Tx_Serial;
  logic                     o_Tx_Done;

  // Upstream word producer (CPU MMIO side).
  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Clks_Per_Bit, i_Parity_Mode, i_Two_Stop,
    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  // The transmitter itself.
  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Clks_Per_Bit, i_Parity_Mode, i_Two_Stop,
    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, DATA_WIDTH data bits LSB
// first, optional even/odd parity, one or two stop bits, bit period set by a
// runtime divisor. Word, divisor and frame format are captured when a word is
// accepted so the frame on the line never sees later input changes.
module uart_tx_cfg #(
  parameter int DATA_WIDTH    = 8,
  parameter int CLK_DIV_WIDTH = 16
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_tx_cfg_if.slave  tx
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Control state (reset)
  state_t                   state_q;
  logic [CLK_DIV_WIDTH-1:0] cnt_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     stop2_q;
  logic                     serial_q;
  logic                     active_q;
  logic                     ready_q;
  logic                     done_q;

  // Captured frame contents (no reset; only loaded on accept)
  logic [DATA_WIDTH-1:0]    shift_q;
  logic [CLK_DIV_WIDTH-1:0] div_q;
  logic                     par_en_q;
  logic                     par_bit_q;
  logic                     two_stop_q;

  // Next-state helpers
  logic [CLK_DIV_WIDTH-1:0] div_d;
  logic                     par_en_d;
  logic                     par_bit_d;
  logic                     bit_end_d;
  logic                     accept_d;
  logic                     shift_en_d;

  // Decode the incoming configuration and the bit-period boundary.
  always_comb begin
    div_d      = (tx.i_Clks_Per_Bit < CLK_DIV_WIDTH'(2)) ? CLK_DIV_WIDTH'(2)
                                                         : tx.i_Clks_Per_Bit;
    par_en_d   = (tx.i_Parity_Mode == 2'b01) || (tx.i_Parity_Mode == 2'b10);
    par_bit_d  = (^tx.i_Tx_Byte) ^ (tx.i_Parity_Mode == 2'b10);
    bit_end_d  = (cnt_q == (div_q - CLK_DIV_WIDTH'(1)));
    // ready_q is only ever high in IDLE, so it doubles as the accept qualifier.
    accept_d   = ready_q && tx.i_Tx_DV;
    shift_en_d = (state_q == DATA) && bit_end_d && (idx_q != LAST_IDX);
  end

  // Capture the word and its frame format on accept; shift data out LSB first.
  always_ff @(posedge i_Clock) begin
    if (accept_d) begin
      shift_q    <= tx.i_Tx_Byte;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= tx.i_Two_Stop;
    end else if (shift_en_d) begin
      shift_q    <= shift_q >> 1;
    end
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop2_q  <= 1'b0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          stop2_q <= 1'b0;
          if (accept_d) begin
            serial_q <= 1'b0;
            active_q <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= START;
          end else begin
            // Also the path that raises ready on the first edge after reset.
            serial_q <= 1'b1;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
          end
        end

        START: begin
          if (bit_end_d) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            serial_q <= shift_q[0];
            state_q  <= DATA;
          end else begin
            cnt_q <= cnt_q + CLK_DIV_WIDTH'(1);
          end
        end

        DATA: begin
          if (bit_end_d) begin
            cnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              if (par_en_q) begin
                serial_q <= par_bit_q;
                state_q  <= PARITY;
              end else begin
                serial_q <= 1'b1;
                stop2_q  <= 1'b0;
                state_q  <= STOP;
              end
            end else begin
              idx_q    <= idx_q + IDX_W'(1);
              serial_q <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CLK_DIV_WIDTH'(1);
          end
        end

        PARITY: begin
          if (bit_end_d) begin
            cnt_q    <= '0;
            serial_q <= 1'b1;
            stop2_q  <= 1'b0;
            state_q  <= STOP;
          end else begin
            cnt_q <= cnt_q + CLK_DIV_WIDTH'(1);
          end
        end

        STOP: begin
          if (bit_end_d) begin
            cnt_q <= '0;
            if (two_stop_q && !stop2_q) begin
              stop2_q <= 1'b1;
            end else begin
              stop2_q  <= 1'b0;
              active_q <= 1'b0;
              done_q   <= 1'b1;
              ready_q  <= 1'b1;
              state_q  <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CLK_DIV_WIDTH'(1);
          end
        end

        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          serial_q <= 1'b1;
          active_q <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Ready  = ready_q;
  assign tx.o_Tx_Done   = done_q;

endmodule
